queue_rr_scheduler: RTL and testbench

Round-robin scheduler that drains up to NumQueues upstream FIFO read ports onto one shared output channel. It grants one queue at a time for a burst of up to Quantum words and pops it with the standard REQ/ACK read handshake. Popped words land in a single registered output stage tagged with the source index. It sits between a bank of two-counter queues and a single downstream consumer, for example a shared bus master or serializer.

---
 rtl/queue_rr_scheduler_if.sv | 29 ++
 rtl/queue_rr_scheduler.sv | 138 +++++++++++++
 tb/tb_queue_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_rr_scheduler_if.sv
// Handshake bundle between the scheduler, its bank of upstream queue read ports and the single downstream consumer.
// master = scheduler side, slave = queue bank / consumer side.
interface queue_rr_scheduler_if #(
   parameter int BitWidth  = 32,
   parameter int NumQueues = 4
);
   localparam int IdxW = $clog2(NumQueues);

   logic [NumQueues-1:0]          qACK;
   logic [NumQueues-1:0]          qREQ;
   logic [NumQueues*BitWidth-1:0] qDATA;
   logic [NumQueues-1:0]          Enable;
   logic                          dOutACK;
   logic                          dOutREQ;
   logic [BitWidth-1:0]           dOUT;
   logic [IdxW-1:0]               dSRC;
   logic                          Busy;
   logic [IdxW-1:0]               GrantIdx;

   modport master (
      input  qACK, qDATA, Enable, dOutREQ,
      output qREQ, dOutACK, dOUT, dSRC, Busy, GrantIdx
   );

   modport slave (
      output qACK, qDATA, Enable, dOutREQ,
      input  qREQ, dOutACK, dOUT, dSRC, Busy, GrantIdx
   );
endinterface

// File: rtl/queue_rr_scheduler.sv
// Round-robin drain of NumQueues queue read ports into one registered output stage, bursts of up to Quantum words.
// Grant one cycle after a candidate appears, word out one cycle after its pop; pops stall while the output is full and unconsumed.
module queue_rr_scheduler #(
   parameter int BitWidth  = 32,
   parameter int NumQueues = 4,
   parameter int Quantum   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   queue_rr_scheduler_if.master  bus
);
   localparam int IdxW = $clog2(NumQueues);
   localparam int CntW = (Quantum > 1) ? $clog2(Quantum) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      g_q, g_d;
   logic [IdxW-1:0]      last_grant_q, last_grant_d;
   logic [CntW-1:0]      burst_cnt_q, burst_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [BitWidth-1:0]  out_data_q, out_data_d;
   logic [IdxW-1:0]      out_src_q, out_src_d;

   logic [NumQueues-1:0] cand;
   logic                 pick_vld;
   logic [IdxW-1:0]      pick_idx;
   logic                 g_live;
   logic                 pop;
   logic                 last_beat;
   logic [BitWidth-1:0]  sel_data;
   logic [NumQueues-1:0] qreq;

   assign cand      = bus.qACK & bus.Enable;
   assign g_live    = bus.qACK[g_q] & bus.Enable[g_q];
   assign last_beat = (burst_cnt_q == CntW'(Quantum - 1));
   assign sel_data  = bus.qDATA[g_q*BitWidth +: BitWidth];

   // Gating with rst keeps queue contents intact while reset is being applied.
   assign pop = (state_q == GRANT) && g_live && (!out_valid_q || bus.dOutREQ) && !rst;

   // First candidate after the last grant, wrapping around.
   always_comb begin
      int unsigned idx;
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
      for (int k = 1; k <= NumQueues; k++) begin
         idx = 32'(last_grant_q) + 32'(k);
         if (idx >= NumQueues) begin
            idx = idx - NumQueues;
         end
         if (!pick_vld && cand[IdxW'(idx)]) begin
            pick_vld = 1'b1;
            pick_idx = IdxW'(idx);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      g_d          = g_q;
      last_grant_d = last_grant_q;
      burst_cnt_d  = burst_cnt_q;

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d      = GRANT;
               g_d          = pick_idx;
               last_grant_d = pick_idx;
               burst_cnt_d  = '0;
            end
         end
         GRANT: begin
            if (pop) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
            if (!g_live) begin
               state_d = IDLE;
            end else if (pop && last_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop and a downstream consume in the same cycle simply reload the stage.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (pop) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_src_d   = g_q;
      end else if (bus.dOutREQ && out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      qreq      = '0;
      qreq[g_q] = pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         g_q          <= '0;
         last_grant_q <= IdxW'(NumQueues - 1);
         burst_cnt_q  <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
      end else begin
         state_q      <= state_d;
         g_q          <= g_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q  <= burst_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
      end
   end

   assign bus.qREQ     = qreq;
   assign bus.dOutACK  = out_valid_q;
   assign bus.dOUT     = out_data_q;
   assign bus.dSRC     = out_src_q;
   assign bus.Busy     = (state_q == GRANT);
   assign bus.GrantIdx = g_q;

endmodule

// File: tb/tb_queue_rr_scheduler.sv
// Directed bench for queue_rr_scheduler: behavioural queue bank on the upstream side, always-ready or stalled consumer downstream.
module tb_queue_rr_scheduler;
   localparam int BW = 32;
   localparam int NQ = 4;
   localparam int QT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   queue_rr_scheduler_if #(.BitWidth(BW), .NumQueues(NQ)) bus();

   queue_rr_scheduler #(
      .BitWidth (BW),
      .NumQueues(NQ),
      .Quantum  (QT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Queue bank model: circular buffers, popped on qREQ at the clock edge.
   logic [BW-1:0] mem [NQ][32];
   int unsigned   rd_ptr [NQ] = '{default: 0};
   int unsigned   wr_ptr [NQ] = '{default: 0};
   int            pop_empty = 0;

   always @(posedge clk) begin
      for (int i = 0; i < NQ; i++) begin
         if (bus.qREQ[i]) begin
            if (rd_ptr[i] == wr_ptr[i]) pop_empty <= pop_empty + 1;
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         bus.qACK[i]           = (rd_ptr[i] != wr_ptr[i]);
         bus.qDATA[i*BW +: BW] = mem[i][rd_ptr[i][4:0]];
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int q, input logic [BW-1:0] v);
      mem[q][wr_ptr[q][4:0]] = v;
      wr_ptr[q] = wr_ptr[q] + 1;
   endtask

   // Leaves rst asserted and the queue bank empty; caller loads and releases.
   task automatic do_reset;
      rst         = 1'b1;
      bus.Enable  = '1;
      bus.dOutREQ = 1'b1;
      next_cycle;
      next_cycle;
      for (int i = 0; i < NQ; i++) wr_ptr[i] = rd_ptr[i];
   endtask

   task automatic test_reset;
      do_reset;
      push(0, 32'hA0);
      @(negedge clk);
      n_cmp++; if (bus.dOutACK !== 1'b0) begin n_err++; $display("FAIL reset_dOutACK got %b want 0", bus.dOutACK); end
      n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_Busy got %b want 0", bus.Busy); end
      n_cmp++; if (bus.qREQ !== 4'b0000) begin n_err++; $display("FAIL reset_qREQ got %b want 0000", bus.qREQ); end
      n_cmp++; if (bus.dOUT !== 32'h0) begin n_err++; $display("FAIL reset_dOUT got %h want 0", bus.dOUT); end
      n_cmp++; if (bus.dSRC !== 2'd0 || bus.GrantIdx !== 2'd0) begin n_err++; $display("FAIL reset_idx got dSRC=%0d GrantIdx=%0d want 0/0", bus.dSRC, bus.GrantIdx); end
      next_cycle;
   endtask

   task automatic test_basic_drain;
      bit [5:0] e_req  = 6'b001110;
      bit [5:0] e_busy = 6'b011110;
      bit [5:0] e_vld  = 6'b011100;
      do_reset;
      for (int k = 0; k < 3; k++) push(0, 32'hA0 + k);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_cmp++; if (bus.qREQ !== (e_req[c] ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL drain_qREQ c%0d got %b want %b", c, bus.qREQ, e_req[c] ? 4'b0001 : 4'b0000); end
         n_cmp++; if (bus.Busy !== e_busy[c]) begin n_err++; $display("FAIL drain_Busy c%0d got %b want %b", c, bus.Busy, e_busy[c]); end
         n_cmp++; if (bus.dOutACK !== e_vld[c]) begin n_err++; $display("FAIL drain_dOutACK c%0d got %b want %b", c, bus.dOutACK, e_vld[c]); end
         if (e_vld[c]) begin
            n_cmp++; if (bus.dOUT !== 32'(32'hA0 + c - 2) || bus.dSRC !== 2'd0) begin n_err++; $display("FAIL drain_word c%0d got %h/src%0d want %h/src0", c, bus.dOUT, bus.dSRC, 32'hA0 + c - 2); end
         end
         next_cycle;
      end
   endtask

   task automatic test_round_robin;
      int src_l[$];
      logic [BW-1:0] dat_l[$];
      int cyc_l[$];
      int cnt[NQ];
      int es, eg;
      do_reset;
      for (int q = 0; q < NQ; q++) for (int k = 0; k < 6; k++) push(q, 32'(32'h100*(q+1) + k));
      rst = 1'b0;
      for (int c = 0; c < 200 && src_l.size() < 24; c++) begin
         @(negedge clk);
         if (bus.dOutACK && bus.dOutREQ) begin src_l.push_back(int'(bus.dSRC)); dat_l.push_back(bus.dOUT); cyc_l.push_back(c); end
         next_cycle;
      end
      n_cmp++; if (src_l.size() != 24) begin n_err++; $display("FAIL rr_count got %0d want 24", src_l.size()); end
      for (int q = 0; q < NQ; q++) cnt[q] = 0;
      for (int w = 0; w < src_l.size(); w++) begin
         es = (w < 16) ? w / 4 : (w - 16) / 2;
         n_cmp++; if (src_l[w] != es || dat_l[w] !== 32'(32'h100*(es+1) + cnt[es])) begin n_err++; $display("FAIL rr_word%0d got src%0d/%h want src%0d/%h", w, src_l[w], dat_l[w], es, 32'h100*(es+1) + cnt[es]); end
         cnt[es]++;
         if (w > 0) begin
            if (w <= 16) eg = (w % 4 == 0) ? 2 : 1;
            else         eg = (w % 2 == 0) ? 3 : 1;
            n_cmp++; if (cyc_l[w] - cyc_l[w-1] != eg) begin n_err++; $display("FAIL rr_gap%0d got %0d want %0d", w, cyc_l[w] - cyc_l[w-1], eg); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [BW-1:0] got_l[$];
      do_reset;
      for (int k = 0; k < 4; k++) push(0, 32'hB0 + k);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         bus.dOutREQ = (c < 3 || c > 7);
         @(negedge clk);
         if (c >= 3 && c <= 7) begin
            n_cmp++; if (bus.dOutACK !== 1'b1 || bus.dOUT !== 32'hB1) begin n_err++; $display("FAIL bp_hold c%0d got %b/%h want 1/000000b1", c, bus.dOutACK, bus.dOUT); end
            n_cmp++; if (bus.qREQ !== 4'b0000 || bus.Busy !== 1'b1 || bus.GrantIdx !== 2'd0) begin n_err++; $display("FAIL bp_grant c%0d got qREQ=%b Busy=%b g=%0d want 0000/1/0", c, bus.qREQ, bus.Busy, bus.GrantIdx); end
         end
         if (bus.dOutACK && bus.dOutREQ) got_l.push_back(bus.dOUT);
         next_cycle;
      end
      n_cmp++; if (got_l.size() != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", got_l.size()); end
      for (int w = 0; w < got_l.size(); w++) begin
         n_cmp++; if (got_l[w] !== 32'(32'hB0 + w)) begin n_err++; $display("FAIL bp_word%0d got %h want %h", w, got_l[w], 32'hB0 + w); end
      end
   endtask

   task automatic test_enable_mask;
      int rot[3] = '{0, 1, 3};
      int src_l[$];
      logic [BW-1:0] dat_l[$];
      int cnt[NQ];
      int es;
      bit saw2 = 1'b0;
      do_reset;
      bus.Enable = 4'b1011;
      for (int q = 0; q < NQ; q++) for (int k = 0; k < 6; k++) push(q, 32'(32'h100*(q+1) + k));
      rst = 1'b0;
      for (int c = 0; c < 300 && src_l.size() < 18; c++) begin
         @(negedge clk);
         if (bus.qREQ[2] || (bus.Busy && bus.GrantIdx == 2'd2)) saw2 = 1'b1;
         if (bus.dOutACK && bus.dOutREQ) begin src_l.push_back(int'(bus.dSRC)); dat_l.push_back(bus.dOUT); end
         next_cycle;
      end
      n_cmp++; if (src_l.size() != 18) begin n_err++; $display("FAIL en_count got %0d want 18", src_l.size()); end
      n_cmp++; if (saw2 !== 1'b0) begin n_err++; $display("FAIL en_q2_granted got %b want 0", saw2); end
      n_cmp++; if (wr_ptr[2] - rd_ptr[2] != 6) begin n_err++; $display("FAIL en_q2_level got %0d want 6", wr_ptr[2] - rd_ptr[2]); end
      for (int q = 0; q < NQ; q++) cnt[q] = 0;
      for (int w = 0; w < src_l.size(); w++) begin
         es = (w < 12) ? rot[w / 4] : rot[(w - 12) / 2];
         n_cmp++; if (src_l[w] != es || dat_l[w] !== 32'(32'h100*(es+1) + cnt[es])) begin n_err++; $display("FAIL en_word%0d got src%0d/%h want src%0d/%h", w, src_l[w], dat_l[w], es, 32'h100*(es+1) + cnt[es]); end
         cnt[es]++;
      end
      bus.Enable = '1;
   endtask

   task automatic test_reset_mid_burst;
      do_reset;
      for (int k = 0; k < 4; k++) push(0, 32'hC0 + k);
      push(1, 32'hD0);
      push(1, 32'hD1);
      rst = 1'b0;
      next_cycle;
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.dOutACK !== 1'b1 || bus.dOUT !== 32'hC0) begin n_err++; $display("FAIL mrst_pre got %b/%h want 1/000000c0", bus.dOutACK, bus.dOUT); end
      next_cycle;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.qREQ !== 4'b0000) begin n_err++; $display("FAIL mrst_qREQ_during got %b want 0000", bus.qREQ); end
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.dOutACK !== 1'b0 || bus.Busy !== 1'b0 || bus.qREQ !== 4'b0000) begin n_err++; $display("FAIL mrst_after got vld=%b Busy=%b qREQ=%b want 0/0/0000", bus.dOutACK, bus.Busy, bus.qREQ); end
      next_cycle;
      rst = 1'b0;
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.Busy !== 1'b1 || bus.GrantIdx !== 2'd0 || bus.qREQ !== 4'b0001) begin n_err++; $display("FAIL mrst_regrant got Busy=%b g=%0d qREQ=%b want 1/0/0001", bus.Busy, bus.GrantIdx, bus.qREQ); end
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.dOutACK !== 1'b1 || bus.dSRC !== 2'd0 || bus.dOUT !== 32'hC2) begin n_err++; $display("FAIL mrst_word got %b/src%0d/%h want 1/src0/000000c2", bus.dOutACK, bus.dSRC, bus.dOUT); end
      next_cycle;
   endtask

   task automatic test_wraparound;
      do_reset;
      push(3, 32'hE0);
      rst = 1'b0;
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.GrantIdx !== 2'd3 || bus.qREQ !== 4'b1000) begin n_err++; $display("FAIL wrap_first got g=%0d qREQ=%b want 3/1000", bus.GrantIdx, bus.qREQ); end
      for (int c = 0; c < 5; c++) next_cycle;
      push(3, 32'hE1);
      @(negedge clk);
      n_cmp++; if (bus.Busy !== 1'b0 || bus.qREQ !== 4'b0000) begin n_err++; $display("FAIL wrap_t0 got Busy=%b qREQ=%b want 0/0000", bus.Busy, bus.qREQ); end
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.Busy !== 1'b1 || bus.GrantIdx !== 2'd3 || bus.qREQ !== 4'b1000) begin n_err++; $display("FAIL wrap_t1 got Busy=%b g=%0d qREQ=%b want 1/3/1000", bus.Busy, bus.GrantIdx, bus.qREQ); end
      next_cycle;
      @(negedge clk);
      n_cmp++; if (bus.dOutACK !== 1'b1 || bus.dSRC !== 2'd3 || bus.dOUT !== 32'hE1) begin n_err++; $display("FAIL wrap_t2 got %b/src%0d/%h want 1/src3/000000e1", bus.dOutACK, bus.dSRC, bus.dOUT); end
      next_cycle;
   endtask

   initial begin
      bus.Enable  = '1;
      bus.dOutREQ = 1'b1;
      test_reset;
      test_basic_drain;
      test_round_robin;
      test_backpressure;
      test_enable_mask;
      test_reset_mid_burst;
      test_wraparound;
      n_cmp++; if (pop_empty != 0) begin n_err++; $display("FAIL pop_on_empty got %0d want 0", pop_empty); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
